// File: rtl/audio_level_meter_pkg.sv
// Shared types, FSM states and the magnitude / bar-count helpers for the
// audio level meter and its per-channel peak trackers.
package audio_pkg;

  localparam int SAMPLE_W = 16;
  localparam int WORD_W   = 32;
  localparam int MAG_W    = SAMPLE_W - 1;
  localparam int BARS_W   = 5;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic        [MAG_W-1:0]    mag_t;
  typedef logic        [BARS_W-1:0]   bars_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    UPDATE,
    PUBLISH
  } meter_state_t;

  // -32768 has no 15-bit magnitude, so it clips to full scale 32767.
  function automatic mag_t abs_sat(input sample_t x);
    if (!x[SAMPLE_W-1]) return x[MAG_W-1:0];
    if (x[MAG_W-1:0] == '0) return '1;
    return ~x[MAG_W-1:0] + mag_t'(1);
  endfunction

  function automatic bars_t mag_to_bars(input mag_t m);
    bars_t bars;
    bars = '0;
    for (int i = 0; i < MAG_W; i++) begin
      if (m[i]) bars = bars_t'(i + 1);
    end
    return bars;
  endfunction

endpackage

// File: rtl/audio_level_meter_channel_peak_tracker.sv
// Per-channel peak accumulator: keeps the largest |sample| seen since the
// last clear and exposes the value it is about to take on an update.
module channel_peak_tracker
  import audio_pkg::*;
(
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                update,
  input  logic                clear,
  output logic [MAG_W-1:0]    peak_next
);

  mag_t acc;
  mag_t mag;

  always_comb begin
    mag       = abs_sat(sample_t'(sample));
    peak_next = acc;
    if (update && (mag > acc)) peak_next = mag;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (update) begin
      acc <= peak_next;
    end
  end

endmodule

// File: rtl/audio_level_meter.sv
// Audio level meter: pops stereo words from the sample FIFO, tracks the
// per-channel absolute peak over WINDOW samples and publishes peaks and bars.
module audio_level_meter
  import audio_pkg::*;
#(
  parameter int WINDOW = 1024
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              rdempty_sig,
  input  logic [WORD_W-1:0] q_sig,
  output logic              rdreq_sig,
  output logic [MAG_W-1:0]  left_peak,
  output logic [MAG_W-1:0]  right_peak,
  output logic [BARS_W-1:0] left_bars,
  output logic [BARS_W-1:0] right_bars,
  output logic              level_valid
);

  localparam int               CNT_W = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WINDOW - 1);

  meter_state_t        state;
  meter_state_t        state_next;
  logic [CNT_W-1:0]    cnt;
  logic [SAMPLE_W-1:0] left_smp;
  logic [SAMPLE_W-1:0] right_smp;
  logic                latch_en;
  logic                update_en;
  logic                publish_en;
  logic                last_sample;
  mag_t                left_next;
  mag_t                right_next;

  assign last_sample = (cnt == LAST);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!rdempty_sig) state_next = READ;
      READ:    state_next = LATCH;
      LATCH:   state_next = UPDATE;
      UPDATE:  state_next = last_sample ? PUBLISH : IDLE;
      PUBLISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rdreq_sig   = 1'b0;
    latch_en    = 1'b0;
    update_en   = 1'b0;
    publish_en  = 1'b0;
    case (state)
      READ:    rdreq_sig  = 1'b1;
      LATCH:   latch_en   = 1'b1;
      UPDATE:  update_en  = 1'b1;
      PUBLISH: publish_en = 1'b1;
      default: ;
    endcase
    level_valid = publish_en;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      left_smp  <= '0;
      right_smp <= '0;
      cnt       <= '0;
    end else begin
      if (latch_en) begin
        left_smp  <= q_sig[WORD_W-1:SAMPLE_W];
        right_smp <= q_sig[SAMPLE_W-1:0];
      end
      if (publish_en) begin
        cnt <= '0;
      end else if (update_en && !last_sample) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Peaks are captured from the trackers' post-update value on the edge into
  // PUBLISH, so they are already stable while level_valid is high.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      left_peak  <= '0;
      right_peak <= '0;
      left_bars  <= '0;
      right_bars <= '0;
    end else if (update_en && last_sample) begin
      left_peak  <= left_next;
      right_peak <= right_next;
      left_bars  <= mag_to_bars(left_next);
      right_bars <= mag_to_bars(right_next);
    end
  end

  channel_peak_tracker u_left (
    .CLOCK_50  (CLOCK_50),
    .RESET_N   (RESET_N),
    .sample    (left_smp),
    .update    (update_en),
    .clear     (publish_en),
    .peak_next (left_next)
  );

  channel_peak_tracker u_right (
    .CLOCK_50  (CLOCK_50),
    .RESET_N   (RESET_N),
    .sample    (right_smp),
    .update    (update_en),
    .clear     (publish_en),
    .peak_next (right_next)
  );

endmodule

// File: tb/tb_audio_level_meter.sv
// Scoreboard bench for audio_level_meter: two instances (WINDOW=4 and 2)
// fed by simple FIFO models with hand-computed expected levels.
module tb_audio_level_meter;

  typedef struct packed {
    logic [14:0] lp;
    logic [14:0] rp;
    logic [4:0]  lb;
    logic [4:0]  rb;
  } level_t;

  logic CLOCK_50 = 1'b0;
  logic RESET_N  = 1'b0;

  always #5 CLOCK_50 = ~CLOCK_50;

  logic        rdempty_a = 1'b1, rdreq_a, valid_a;
  logic [31:0] q_a = '0;
  logic [14:0] lp_a, rp_a;
  logic [4:0]  lb_a, rb_a;
  logic        rdempty_b = 1'b1, rdreq_b, valid_b;
  logic [31:0] q_b = '0;
  logic [14:0] lp_b, rp_b;
  logic [4:0]  lb_b, rb_b;

  logic        push_a = 1'b0, push_b = 1'b0;
  logic [31:0] push_data_a = '0, push_data_b = '0;
  logic [31:0] fifo_a[$];
  logic [31:0] fifo_b[$];

  level_t exp_a[$];
  level_t exp_b[$];
  string  dname_q[$];
  int     dact_q[$];
  int     dexp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cycle = 0;
  int last_rd_a = 0, last_rd_b = 0;
  int rdreq_count_a = 0, rdreq_count_b = 0;

  audio_level_meter #(.WINDOW(4)) u_win4 (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .rdempty_sig (rdempty_a),
    .q_sig       (q_a),
    .rdreq_sig   (rdreq_a),
    .left_peak   (lp_a),
    .right_peak  (rp_a),
    .left_bars   (lb_a),
    .right_bars  (rb_a),
    .level_valid (valid_a)
  );

  audio_level_meter #(.WINDOW(2)) u_win2 (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .rdempty_sig (rdempty_b),
    .q_sig       (q_b),
    .rdreq_sig   (rdreq_b),
    .left_peak   (lp_b),
    .right_peak  (rp_b),
    .left_bars   (lb_b),
    .right_bars  (rb_b),
    .level_valid (valid_b)
  );

  // Non-show-ahead FIFO models: data appears the cycle after rdreq.
  always @(posedge CLOCK_50) begin
    if (rdreq_a && fifo_a.size() > 0) q_a <= fifo_a.pop_front();
    if (push_a) fifo_a.push_back(push_data_a);
    rdempty_a <= (fifo_a.size() == 0);
    if (rdreq_b && fifo_b.size() > 0) q_b <= fifo_b.pop_front();
    if (push_b) fifo_b.push_back(push_data_b);
    rdempty_b <= (fifo_b.size() == 0);
  end

  task automatic compare(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input int inst, input level_t got, input int latency);
    level_t want;
    string  tag;
    tag = (inst == 0) ? "w4" : "w2";
    if ((inst == 0 && exp_a.size() == 0) || (inst == 1 && exp_b.size() == 0)) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL %s_unexpected_level_valid: got pulse with left_peak %0d, expected no pulse",
               tag, got.lp);
      return;
    end
    if (inst == 0) want = exp_a.pop_front();
    else           want = exp_b.pop_front();
    compare({tag, "_left_peak"},  int'(got.lp), int'(want.lp));
    compare({tag, "_right_peak"}, int'(got.rp), int'(want.rp));
    compare({tag, "_left_bars"},  int'(got.lb), int'(want.lb));
    compare({tag, "_right_bars"}, int'(got.rb), int'(want.rb));
    compare({tag, "_publish_latency"}, latency, 3);
  endtask

  // Monitor: the only process that steps the check/error counters.
  always @(negedge CLOCK_50) begin
    cycle++;
    if (rdreq_a) begin
      rdreq_count_a++;
      last_rd_a = cycle;
      compare("w4_rdreq_while_empty", int'(rdempty_a), 0);
    end
    if (rdreq_b) begin
      rdreq_count_b++;
      last_rd_b = cycle;
      compare("w2_rdreq_while_empty", int'(rdempty_b), 0);
    end
    if (valid_a) checkOutput(0, {lp_a, rp_a, lb_a, rb_a}, cycle - last_rd_a);
    if (valid_b) checkOutput(1, {lp_b, rp_b, lb_b, rb_b}, cycle - last_rd_b);
    while (dname_q.size() > 0) compare(dname_q.pop_front(), dact_q.pop_front(), dexp_q.pop_front());
  end

  task automatic postCheck(input string name, input int act, input int exp);
    dname_q.push_back(name);
    dact_q.push_back(act);
    dexp_q.push_back(exp);
  endtask

  task automatic applyStimulus(input int inst, input logic [31:0] word);
    @(negedge CLOCK_50);
    if (inst == 0) begin
      push_a      = 1'b1;
      push_data_a = word;
    end else begin
      push_b      = 1'b1;
      push_data_b = word;
    end
    @(negedge CLOCK_50);
    push_a = 1'b0;
    push_b = 1'b0;
  endtask

  task automatic expectLevel(input int inst, input int lp, input int rp, input int lb, input int rb);
    level_t e;
    e.lp = 15'(lp);
    e.rp = 15'(rp);
    e.lb = 5'(lb);
    e.rb = 5'(rb);
    if (inst == 0) exp_a.push_back(e);
    else           exp_b.push_back(e);
  endtask

  task automatic waitDrain(input int inst, input string name);
    int n;
    n = 0;
    while (((inst == 0) ? exp_a.size() : exp_b.size()) != 0 && n < 300) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (n >= 300) postCheck({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int n;
    int base;

    $display("[TB] reset and first-read latency");
    repeat (2) @(negedge CLOCK_50);
    expectLevel(0, 16, 256, 5, 9);
    applyStimulus(0, 32'h0001_FFFF);
    postCheck("reset_rdreq", int'(rdreq_a), 0);
    postCheck("reset_level_valid", int'(valid_a), 0);
    postCheck("reset_left_peak", int'(lp_a), 0);
    postCheck("reset_right_bars", int'(rb_a), 0);
    RESET_N = 1'b1;
    n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (!rdreq_a && n < 10);
    postCheck("first_rdreq_latency", n, 1);

    $display("[TB] WINDOW=4 basic window");
    applyStimulus(0, 32'h0010_FFF0);
    applyStimulus(0, 32'h0003_0002);
    applyStimulus(0, 32'h0008_0100);
    waitDrain(0, "w4_basic");

    $display("[TB] WINDOW=2 saturation");
    expectLevel(1, 32767, 32767, 15, 15);
    applyStimulus(1, 32'h8000_7FFF);
    applyStimulus(1, 32'h0000_0000);
    waitDrain(1, "w2_saturation");

    $display("[TB] WINDOW=2 window boundary");
    expectLevel(1, 4096, 0, 13, 0);
    applyStimulus(1, 32'h1000_0000);
    applyStimulus(1, 32'h0000_0000);
    expectLevel(1, 1, 0, 1, 0);
    applyStimulus(1, 32'h0001_0000);
    applyStimulus(1, 32'h0000_0000);
    waitDrain(1, "w2_boundary");
    repeat (10) @(negedge CLOCK_50);
    postCheck("w2_hold_left_peak", int'(lp_b), 1);
    postCheck("w2_hold_left_bars", int'(lb_b), 1);

    $display("[TB] WINDOW=4 empty stall mid-window");
    expectLevel(0, 256, 32767, 9, 15);
    applyStimulus(0, 32'h0005_FFFB);
    applyStimulus(0, 32'hFF00_0007);
    n = 0;
    while (fifo_a.size() != 0 && n < 100) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (n >= 100) postCheck("stall_drain_timeout", 0, 1);
    repeat (6) @(negedge CLOCK_50);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLOCK_50);
      if (rdreq_a) n++;
    end
    postCheck("stall_rdreq_pulses", n, 0);
    applyStimulus(0, 32'h0040_8001);
    applyStimulus(0, 32'h0000_0000);
    waitDrain(0, "w4_stall");

    $display("[TB] WINDOW=4 reset during LATCH");
    base = rdreq_count_a;
    applyStimulus(0, 32'h7000_7000);
    applyStimulus(0, 32'h7000_7000);
    n = 0;
    while (rdreq_count_a < base + 2 && n < 200) begin
      @(posedge CLOCK_50);
      n++;
    end
    if (n >= 200) postCheck("midreset_wait_timeout", 0, 1);
    #1 RESET_N = 1'b0;
    #1;
    postCheck("midreset_rdreq", int'(rdreq_a), 0);
    postCheck("midreset_left_peak", int'(lp_a), 0);
    postCheck("midreset_right_bars", int'(rb_a), 0);
    repeat (3) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    expectLevel(0, 32, 64, 6, 7);
    applyStimulus(0, 32'h0020_0003);
    applyStimulus(0, 32'hFFFF_0010);
    applyStimulus(0, 32'h0004_FFC0);
    applyStimulus(0, 32'h0001_0001);
    waitDrain(0, "w4_after_reset");

    repeat (10) @(negedge CLOCK_50);
    postCheck("w4_pending_levels", exp_a.size(), 0);
    postCheck("w2_pending_levels", exp_b.size(), 0);
    repeat (3) @(negedge CLOCK_50);
    @(posedge CLOCK_50);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
